// File: rtl/pifo_buf_pkg.sv
// Shared types and default widths for the packet-buffer write path.
// Pure declarations: no logic, no latency, no backpressure.
// Consumers import this package and override widths through their own parameters.
package pifo_buf_pkg;

    localparam int DEF_N_PORTS       = 4;
    localparam int DEF_DATA_WIDTH    = 256;
    localparam int DEF_ADDR_WIDTH    = 12;
    localparam int DEF_MAX_PKT_WORDS = 48;
    localparam int DEF_PORT_WIDTH    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_DESC    = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] sop_addr;
        logic [DEF_ADDR_WIDTH-1:0] len;
        logic [DEF_PORT_WIDTH-1:0] port;
        logic                      err;
    } desc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr wins.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to register the grant.
module rr_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int PORT_WIDTH = 2
) (
    input  logic [N_PORTS-1:0]    req,
    input  logic [PORT_WIDTH-1:0] ptr,
    output logic [PORT_WIDTH-1:0] grant,
    output logic                  any_grant
);

    int idx;

    // Scan from the lowest priority upward so the last hit is the winner.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = N_PORTS; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N_PORTS;
            if (req[idx]) begin
                grant     = PORT_WIDTH'(idx);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buf_wr_arbiter.sv
// Packet-granular round-robin owner of the buffer write path; emits one descriptor per packet.
// Latency: grant one cycle after valid in IDLE, then one word per cycle; descriptor after tlast.
// Backpressure: only the granted port sees tready; all ports stall while a descriptor waits.
module buf_wr_arbiter
    import pifo_buf_pkg::*;
#(
    parameter int N_PORTS       = DEF_N_PORTS,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS,
    parameter int PORT_WIDTH    = DEF_PORT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            s_axis_tvalid,
    output logic [N_PORTS-1:0]            s_axis_tready,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_PORTS-1:0]            s_axis_tlast,
    input  logic [ADDR_WIDTH-1:0]         i_fl_head,
    input  logic [ADDR_WIDTH-1:0]         i_remain_space,
    output logic                          o_wr_en,
    output logic [ADDR_WIDTH-1:0]         o_wr_addr,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    output logic                          m_desc_valid,
    input  logic                          m_desc_ready,
    output logic [ADDR_WIDTH-1:0]         m_desc_sop_addr,
    output logic [ADDR_WIDTH-1:0]         m_desc_len,
    output logic [PORT_WIDTH-1:0]         m_desc_port,
    output logic                          m_desc_err,
    output logic [31:0]                   o_pkt_count
);

    wr_state_t             state;
    logic [PORT_WIDTH-1:0] gnt;
    logic [PORT_WIDTH-1:0] rr_ptr;
    logic [PORT_WIDTH-1:0] arb_gnt;
    logic                  arb_any;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [ADDR_WIDTH-1:0] sop_addr;
    logic                  err;
    logic                  desc_vld;
    logic [31:0]           pkt_count;

    logic                  g_vld;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_dat;
    logic                  at_max;
    logic                  space_ok;

    rr_arbiter #(
        .N_PORTS    (N_PORTS),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_rr (
        .req       (s_axis_tvalid),
        .ptr       (rr_ptr),
        .grant     (arb_gnt),
        .any_grant (arb_any)
    );

    assign g_vld    = s_axis_tvalid[gnt];
    assign g_last   = s_axis_tlast[gnt];
    assign g_dat    = s_axis_tdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
    assign at_max   = (word_cnt == ADDR_WIDTH'(MAX_PKT_WORDS));
    // Reserving a full max-size packet up front means a granted packet can never overrun.
    assign space_ok = (i_remain_space >= ADDR_WIDTH'(MAX_PKT_WORDS));

    always_comb begin
        s_axis_tready = '0;
        o_wr_en       = 1'b0;
        o_wr_addr     = '0;
        o_wr_data     = '0;
        if (state == ST_XFER || state == ST_DISCARD) begin
            s_axis_tready[gnt] = 1'b1;
        end
        if (state == ST_XFER) begin
            o_wr_en   = g_vld && !at_max;
            o_wr_addr = i_fl_head;
            o_wr_data = g_dat;
        end
    end

    assign m_desc_valid    = desc_vld;
    assign m_desc_sop_addr = sop_addr;
    assign m_desc_len      = word_cnt;
    assign m_desc_port     = gnt;
    assign m_desc_err      = err;
    assign o_pkt_count     = pkt_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= PORT_WIDTH'(N_PORTS - 1);
            word_cnt  <= '0;
            sop_addr  <= '0;
            err       <= 1'b0;
            desc_vld  <= 1'b0;
            pkt_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any && space_ok) begin
                        gnt      <= arb_gnt;
                        rr_ptr   <= arb_gnt;
                        word_cnt <= '0;
                        err      <= 1'b0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (g_vld) begin
                        if (at_max) begin
                            // Overlong packet: drop this word and the rest, keep the count at max.
                            err <= 1'b1;
                            if (g_last) begin
                                desc_vld <= 1'b1;
                                state    <= ST_DESC;
                            end else begin
                                state <= ST_DISCARD;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt == '0) begin
                                sop_addr <= i_fl_head;
                            end
                            if (g_last) begin
                                desc_vld <= 1'b1;
                                state    <= ST_DESC;
                            end
                        end
                    end
                end
                ST_DISCARD: begin
                    if (g_vld && g_last) begin
                        desc_vld <= 1'b1;
                        state    <= ST_DESC;
                    end
                end
                ST_DESC: begin
                    if (m_desc_ready) begin
                        desc_vld  <= 1'b0;
                        pkt_count <= pkt_count + 32'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buf_wr_arbiter.sv
// Scoreboard bench for buf_wr_arbiter: expected writes/descriptors queued at issue,
// a negedge monitor pops and compares whenever the DUT writes or hands off a descriptor.
module tb_buf_wr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 256;
    localparam int AW   = 12;
    localparam int MAXW = 48;
    localparam int PW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    tvalid;
    logic [N-1:0]    tready;
    logic [N*DW-1:0] tdata;
    logic [N-1:0]    tlast;
    logic [AW-1:0]   fl_head;
    logic [AW-1:0]   remain;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            desc_valid;
    logic            desc_ready;
    logic [AW-1:0]   desc_sop;
    logic [AW-1:0]   desc_len;
    logic [PW-1:0]   desc_port;
    logic            desc_err;
    logic [31:0]     pkt_count;

    always #5 clk = ~clk;

    buf_wr_arbiter #(
        .N_PORTS       (N),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .MAX_PKT_WORDS (MAXW),
        .PORT_WIDTH    (PW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tvalid   (tvalid),
        .s_axis_tready   (tready),
        .s_axis_tdata    (tdata),
        .s_axis_tlast    (tlast),
        .i_fl_head       (fl_head),
        .i_remain_space  (remain),
        .o_wr_en         (wr_en),
        .o_wr_addr       (wr_addr),
        .o_wr_data       (wr_data),
        .m_desc_valid    (desc_valid),
        .m_desc_ready    (desc_ready),
        .m_desc_sop_addr (desc_sop),
        .m_desc_len      (desc_len),
        .m_desc_port     (desc_port),
        .m_desc_err      (desc_err),
        .o_pkt_count     (pkt_count)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] sop;
        logic [AW-1:0] len;
        logic [PW-1:0] port;
        logic          err;
    } dsc_t;

    wr_t           exp_wr[$];
    dsc_t          exp_dsc[$];
    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] exp_head;

    function automatic logic [DW-1:0] word_dat(input int tag, input int idx);
        logic [31:0] w;
        w = 32'hA000_0000 | 32'(tag << 8) | 32'(idx);
        return {8{w}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_pkt(input int p, input int tag, input int nw, input int len,
                            input logic err, input logic with_desc);
        dsc_t d;
        for (int i = 0; i < nw; i++) begin
            wr_t e;
            e.addr = exp_head + AW'(i);
            e.data = word_dat(tag, i);
            exp_wr.push_back(e);
        end
        d.sop  = exp_head;
        d.len  = AW'(len);
        d.port = PW'(p);
        d.err  = err;
        if (with_desc) exp_dsc.push_back(d);
        exp_head = exp_head + AW'(nw);
    endtask

    // Drives one packet on port p, holding each word until the DUT accepts it.
    task automatic send_pkt(input int p, input int tag, input int n);
        int   w = 0;
        int   cyc = 0;
        logic acc;
        tvalid[p] = 1'b1;
        tdata[p*DW +: DW] = word_dat(tag, 0);
        tlast[p] = (n == 1);
        while (w < n && cyc < 400) begin
            @(negedge clk);
            acc = tready[p];
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                w++;
                if (w < n) begin
                    tdata[p*DW +: DW] = word_dat(tag, w);
                    tlast[p] = (w == n - 1);
                end
            end
        end
        tvalid[p] = 1'b0;
        tlast[p]  = 1'b0;
        total++;
        if (w != n) begin
            bad++;
            $display("FAIL send_p%0d_t%0d: accepted %0d words expected %0d", p, tag, w, n);
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((exp_wr.size() != 0 || exp_dsc.size() != 0) && c < 500) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        check(name, 64'(exp_wr.size() + exp_dsc.size()), 64'd0);
    endtask

    // Address-manager model: head advances one entry after every write.
    initial begin
        logic hw;
        fl_head = 12'd10;
        forever begin
            @(negedge clk);
            hw = wr_en;
            @(posedge clk);
            #1;
            if (hw) fl_head = fl_head + 1'b1;
        end
    end

    initial begin
        wr_t  e;
        dsc_t d;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: addr=%0d", wr_addr);
                end else begin
                    e = exp_wr.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        bad++;
                        $display("FAIL write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                 wr_addr, wr_data[31:0], e.addr, e.data[31:0]);
                    end
                end
            end
            if (desc_valid === 1'b1 && desc_ready === 1'b1) begin
                total++;
                if (exp_dsc.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_desc: sop=%0d len=%0d port=%0d", desc_sop, desc_len, desc_port);
                end else begin
                    d = exp_dsc.pop_front();
                    if ({desc_sop, desc_len, desc_port, desc_err} !== d) begin
                        bad++;
                        $display("FAIL desc: got sop=%0d len=%0d port=%0d err=%0d expected sop=%0d len=%0d port=%0d err=%0d",
                                 desc_sop, desc_len, desc_port, desc_err, d.sop, d.len, d.port, d.err);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] sop0;
        logic          acc;
        int            w;
        int            c;

        rst        = 1'b1;
        tvalid     = '0;
        tlast      = '0;
        tdata      = '0;
        remain     = 12'd100;
        desc_ready = 1'b1;
        exp_head   = 12'd10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_wr", 64'({wr_en, wr_addr}), 64'd0);
        check("rst_desc", 64'({desc_valid, desc_sop, desc_len, desc_port, desc_err}), 64'd0);
        check("rst_cnt", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single port, 3 words at heads 10..12.
        push_pkt(0, 1, 3, 3, 1'b0, 1'b1);
        send_pkt(0, 1, 3);
        drain("single_drain");
        check("single_cnt", 64'(pkt_count), 64'd1);

        // Fairness between ports 1 and 3: order 1,3,1,3.
        push_pkt(1, 2, 2, 2, 1'b0, 1'b1);
        push_pkt(3, 3, 2, 2, 1'b0, 1'b1);
        push_pkt(1, 4, 2, 2, 1'b0, 1'b1);
        push_pkt(3, 5, 2, 2, 1'b0, 1'b1);
        fork
            begin send_pkt(1, 2, 2); send_pkt(1, 4, 2); end
            begin send_pkt(3, 3, 2); send_pkt(3, 5, 2); end
        join
        drain("fair_drain");
        check("fair_cnt", 64'(pkt_count), 64'd5);

        // Admission: 47 free words blocks, 48 grants one cycle later.
        remain = 12'd47;
        push_pkt(0, 6, 1, 1, 1'b0, 1'b1);
        tvalid[0] = 1'b1;
        tdata[0 +: DW] = word_dat(6, 0);
        tlast[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("adm_block", 64'({tready, wr_en}), 64'd0);
            @(posedge clk);
            #1;
        end
        remain = 12'd48;
        @(negedge clk);
        check("adm_same_cycle", 64'(tready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("adm_grant", 64'(tready), 64'b0001);
        @(posedge clk);
        #1;
        tvalid[0] = 1'b0;
        tlast[0]  = 1'b0;
        remain    = 12'd100;
        drain("adm_drain");

        // Truncation: 50 words, 48 written, descriptor err.
        push_pkt(2, 7, MAXW, MAXW, 1'b1, 1'b1);
        send_pkt(2, 7, 50);
        drain("trunc_drain");
        check("trunc_cnt", 64'(pkt_count), 64'd7);

        // Descriptor stall with port 1 waiting behind it.
        desc_ready = 1'b0;
        sop0 = exp_head;
        push_pkt(0, 8, 1, 1, 1'b0, 1'b1);
        push_pkt(1, 9, 1, 1, 1'b0, 1'b1);
        fork
            send_pkt(0, 8, 1);
            send_pkt(1, 9, 1);
            begin
                c = 0;
                @(negedge clk);
                while (desc_valid !== 1'b1 && c < 50) begin
                    @(negedge clk);
                    c++;
                end
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stall_hold",
                          64'({desc_valid, desc_sop, desc_len, desc_port, desc_err, tready}),
                          64'({1'b1, sop0, 12'd1, 2'd0, 1'b0, 4'b0000}));
                end
                @(posedge clk);
                #1;
                desc_ready = 1'b1;
            end
        join
        drain("stall_drain");
        check("stall_cnt", 64'(pkt_count), 64'd9);

        // Reset after word 2 of a 4-word packet.
        push_pkt(0, 10, 2, 0, 1'b0, 1'b0);
        tvalid[0] = 1'b1;
        tdata[0 +: DW] = word_dat(10, 0);
        tlast[0] = 1'b0;
        w = 0;
        c = 0;
        while (w < 2 && c < 50) begin
            @(negedge clk);
            acc = tready[0];
            @(posedge clk);
            #1;
            c++;
            if (acc) begin
                w++;
                tdata[0 +: DW] = word_dat(10, w);
            end
        end
        rst = 1'b1;
        tvalid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out", 64'({tready, wr_en, desc_valid}), 64'd0);
        check("mid_rst_cnt", 64'(pkt_count), 64'd0);
        check("mid_rst_words", 64'(exp_wr.size()), 64'd0);
        @(posedge clk);
        #1;
        push_pkt(0, 11, 1, 1, 1'b0, 1'b1);
        push_pkt(1, 12, 1, 1, 1'b0, 1'b1);
        fork
            send_pkt(0, 11, 1);
            send_pkt(1, 12, 1);
        join
        drain("post_rst_drain");
        check("post_rst_cnt", 64'(pkt_count), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
